// File: rtl/rtc_coord_dispatcher.sv
// rtc_coord_dispatcher
//   Producer side of the RTC job interface. On an accepted start it walks a
//   WIDTH x HEIGHT viewport in raster order and offers one job at a time:
//   a linear pixel index plus the complex-plane start point (x0, y0).
//   Coordinates are produced by running accumulators (no multipliers).
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   start          in   one-cycle frame start, honoured only when idle
//   x_min          in   real part of the left column (sampled on start)
//   y_max          in   imaginary part of the top row (sampled on start)
//   step           in   per-pixel increment (sampled on start)
//   rtc_poll_ready out  job valid and poppable
//   idx_to_rtc     out  pixel index row*WIDTH+col, all-ones when idle
//   x0_to_rtc      out  job real part
//   y0_to_rtc      out  job imaginary part
//   rtc_read       in   consumer pop, effective only while rtc_poll_ready=1
//   busy           out  frame in progress
//   frame_done     out  one-cycle pulse after the last job's hold cycle
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no frame in progress, waiting for start
// S_PRESENT | job offered, waiting for a pop
// S_HOLD  | one cycle after a pop; job data held for the consumer

module rtc_coord_dispatcher #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int COORD_W = 64,
  parameter int IDX_W   = 17
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] x_min,
  input  logic [COORD_W-1:0] y_max,
  input  logic [COORD_W-1:0] step,
  output logic               rtc_poll_ready,
  output logic [IDX_W-1:0]   idx_to_rtc,
  output logic [COORD_W-1:0] x0_to_rtc,
  output logic [COORD_W-1:0] y0_to_rtc,
  input  logic               rtc_read,
  output logic               busy,
  output logic               frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_HOLD} state_t;

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [IDX_W-1:0] IDX_NULL = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH * HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COORD_W-1:0] x_min_q, x_min_d;
  logic [COORD_W-1:0] step_q, step_d;
  logic               rdy_q, rdy_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COORD_W-1:0] x0_q, x0_d;
  logic [COORD_W-1:0] y0_q, y0_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      x_min_q <= '0;
      step_q  <= '0;
      rdy_q   <= 1'b0;
      idx_q   <= IDX_NULL;
      x0_q    <= '0;
      y0_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      x_min_q <= x_min_d;
      step_q  <= step_d;
      rdy_q   <= rdy_d;
      idx_q   <= idx_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    x_min_d = x_min_q;
    step_d  = step_q;
    rdy_d   = rdy_q;
    idx_d   = idx_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // y_max is only needed for the first row; after that y0 itself
          // is the running accumulator, so it is loaded directly.
          state_d = S_PRESENT;
          x_min_d = x_min;
          step_d  = step;
          col_d   = '0;
          row_d   = '0;
          idx_d   = '0;
          x0_d    = x_min;
          y0_d    = y_max;
          rdy_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_PRESENT: begin
        if (rtc_read) begin
          state_d = S_HOLD;
          rdy_d   = 1'b0;
        end
      end
      S_HOLD: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_IDLE;
          idx_d   = IDX_NULL;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_PRESENT;
          rdy_d   = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
            x0_d  = x_min_q;
            y0_d  = y0_q - step_q;
          end else begin
            col_d = col_q + COL_W'(1);
            x0_d  = x0_q + step_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rtc_poll_ready = rdy_q;
  assign idx_to_rtc     = idx_q;
  assign x0_to_rtc      = x0_q;
  assign y0_to_rtc      = y0_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;

endmodule
